axi4_lite_req_arbiter: RTL and testbench
========================================

AXI4_LITE_REQ_ARBITER -- requirements
Module: axi4_lite_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 arst_n  input  1  reset, asynchronous assert, active low.
REQ-006 req_valid  input  NUM_REQ  per-requester command request.
REQ-007 req_we  input  NUM_REQ  per-requester command type: 1 write, 0 read.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  input  NUM_REQ*DATA_W  per-requester write data, same packing.
REQ-010 req_done  output  NUM_REQ  one-cycle completion pulse per requester.
REQ-011 req_rdata  output  DATA_W  read data, shared, valid with a read req_done pulse.
REQ-012 grant  output  NUM_REQ  one-hot owner of the current transaction, 0 when idle.
REQ-013 wr_addr, wr_data  output  ADDR_W, DATA_W  write command to the AXI4-Lite master controller.
REQ-014 wr_valid  output  1  write command valid; wr_ready  input  1  write-complete pulse from the controller.
REQ-015 rd_addr  output  ADDR_W  read command to the controller; rd_valid  output  1  read command valid.
REQ-016 rd_data  input  DATA_W  and rd_ready  input  1  are read data and read-complete pulse from the controller.

Function
REQ-017 The block SHALL run one transaction at a time, with FSM states IDLE, WR and RD.
REQ-018 In IDLE with any req_valid high, the block SHALL latch the winner's we/addr/wdata at the clock edge, set grant one-hot, and go to WR or RD.
REQ-019 Arbitration SHALL be round-robin: search starts at index last_grant+1 modulo NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-020 In WR, wr_valid SHALL be 1 and wr_addr/wr_data SHALL hold the latched values, stable until wr_ready is sampled high.
REQ-021 In RD, rd_valid SHALL be 1 and rd_addr SHALL hold the latched value, stable until rd_ready is sampled high.
REQ-022 On wr_ready=1 in WR, at that edge: wr_valid->0, req_done[g]=1 for exactly one cycle, grant->0, state->IDLE.
REQ-023 On rd_ready=1 in RD, at that edge: rd_valid->0, req_rdata<=rd_data, req_done[g]=1 for one cycle, grant->0, state->IDLE.
REQ-024 Latency from req_valid seen in IDLE to wr_valid/rd_valid high SHALL be 1 cycle; from ready to req_done SHALL be 1 cycle; back-to-back grants SHALL have exactly one IDLE cycle between them.
REQ-025 wr_ready in RD, rd_ready in WR, and either ready in IDLE SHALL be ignored.
REQ-026 Requester input changes after grant SHALL be ignored until req_done; a requester dropping req_valid before grant SHALL simply lose arbitration.
REQ-027 A requester still holding req_valid in the req_done cycle SHALL be treated as a new request at the next IDLE arbitration.
REQ-028 req_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-029 wr_valid and rd_valid SHALL never be high at the same time.

Reset
REQ-030 On arst_n low, the block SHALL immediately force state IDLE, wr_valid=0, rd_valid=0, grant=0, req_done=0, req_rdata=0, wr_addr/wr_data/rd_addr=0 and last_grant=NUM_REQ-1.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no req_done; after arst_n deassertion the first arbitration SHALL occur at the first edge in IDLE.

Structure
REQ-032 A shared package axi4l_arb_pkg SHALL hold the FSM state encodings (IDLE, WR, RD) and default width constants.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last_grant; output: one-hot winner, combinational).
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Single write: req_valid[2]=1, we=1, addr=0x10, wdata=0xA5A5A5A5 -> next cycle wr_valid=1 with those values, grant=4'b0100; wr_ready after 3 cycles -> req_done[2] pulse of 1 cycle.
REQ-036 Single read: req 1 reads 0x20; rd_ready with rd_data=0xDEADBEEF -> req_rdata=0xDEADBEEF with req_done[1].
REQ-037 Fairness: all 4 requesters hold req_valid out of reset -> grant order 0,1,2,3,0, one IDLE cycle between grants.
REQ-038 Stray ready: rd_ready pulsed in WR and wr_ready pulsed in IDLE -> no state change, no req_done.
REQ-039 Reset mid-transaction: arst_n low during WR -> wr_valid=0 and grant=0 immediately; no req_done; requester 0 wins first after release.
REQ-040 Input stability: change req_addr[0] to 0x44 after grant -> wr_addr stays 0x10 until wr_ready.

Source files
------------

// File: rtl/axi4_lite_req_arbiter_pkg.sv
// Shared types and default widths for the AXI4-Lite request arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding (IDLE/WR/RD) and default parameter values.
package axi4l_arb_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// Command channel between the request arbiter and the AXI4-Lite master controller.
// Latency: n/a (wires only).
// Backpressure: a command stays valid until the matching *_ready completion pulse.
// Ports: master = arbiter side (drives wr_*/rd_addr/rd_valid),
//        slave  = controller side (drives wr_ready, rd_ready, rd_data).
interface axi4_lite_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;

  modport master (
    output wr_addr, wr_data, wr_valid, rd_addr, rd_valid,
    input  wr_ready, rd_data, rd_ready
  );

  modport slave (
    input  wr_addr, wr_data, wr_valid, rd_addr, rd_valid,
    output wr_ready, rd_data, rd_ready
  );

endinterface

// File: rtl/axi4_lite_req_arbiter_rr_arbiter.sv
// Round-robin pick: first requester after last_grant (wrapping) wins.
// Latency: combinational.
// Backpressure: none; the caller decides when the winner is consumed.
// Ports: req (request vector), last_grant (index of previous owner), win (one-hot, 0 if no request).
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] win
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan last_grant+1 .. last_grant+NUM_REQ; the final step revisits
  // last_grant itself, so a lone repeat requester still wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Multiplexes NUM_REQ single-command requesters onto one AXI4-Lite controller, one transaction at a time.
// Latency: request->command valid 1 cycle; ready->req_done 1 cycle; one IDLE cycle between grants.
// Backpressure: command held until wr_ready/rd_ready pulse; losing requesters wait by holding req_valid.
// Ports: clk/arst_n; req_valid/req_we/req_addr/req_wdata in, req_done/req_rdata/grant out; ctl = controller channel.
module axi4_lite_req_arbiter
  import axi4l_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        grant,
  axi4_lite_req_arbiter_if.master   ctl
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  last_grant, last_grant_nxt;
  logic [NUM_REQ-1:0] grant_nxt, req_done_nxt;
  logic [DATA_W-1:0] req_rdata_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt, rd_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic              wr_valid_nxt, rd_valid_nxt;

  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .win        (win)
  );

  // Steer the winner's command fields out of the packed request buses.
  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) begin
        win_idx   = IDX_W'(i);
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    req_done_nxt   = '0;
    req_rdata_nxt  = req_rdata;
    wr_addr_nxt    = ctl.wr_addr;
    wr_data_nxt    = ctl.wr_data;
    rd_addr_nxt    = ctl.rd_addr;
    wr_valid_nxt   = ctl.wr_valid;
    rd_valid_nxt   = ctl.rd_valid;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_nxt      = win;
          last_grant_nxt = win_idx;
          if (win_we) begin
            state_nxt    = WR;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = win_addr;
            wr_data_nxt  = win_wdata;
          end else begin
            state_nxt    = RD;
            rd_valid_nxt = 1'b1;
            rd_addr_nxt  = win_addr;
          end
        end
      end
      // rd_ready is meaningless here and deliberately not looked at.
      WR: begin
        if (ctl.wr_ready) begin
          state_nxt    = IDLE;
          wr_valid_nxt = 1'b0;
          req_done_nxt = grant;
          grant_nxt    = '0;
        end
      end
      RD: begin
        if (ctl.rd_ready) begin
          state_nxt     = IDLE;
          rd_valid_nxt  = 1'b0;
          req_rdata_nxt = ctl.rd_data;
          req_done_nxt  = grant;
          grant_nxt     = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      grant        <= '0;
      req_done     <= '0;
      req_rdata    <= '0;
      ctl.wr_addr  <= '0;
      ctl.wr_data  <= '0;
      ctl.rd_addr  <= '0;
      ctl.wr_valid <= 1'b0;
      ctl.rd_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      last_grant   <= last_grant_nxt;
      grant        <= grant_nxt;
      req_done     <= req_done_nxt;
      req_rdata    <= req_rdata_nxt;
      ctl.wr_addr  <= wr_addr_nxt;
      ctl.wr_data  <= wr_data_nxt;
      ctl.rd_addr  <= rd_addr_nxt;
      ctl.wr_valid <= wr_valid_nxt;
      ctl.rd_valid <= rd_valid_nxt;
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Directed self-checking bench for axi4_lite_req_arbiter (NUM_REQ=4, 32-bit address/data).
// Latency: n/a.
// Backpressure: controller ready pulses are driven directly by the stimulus.
module tb_axi4_lite_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            arst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_done;
  logic [DW-1:0]   req_rdata;
  logic [N-1:0]    grant;

  int checks = 0;
  int errors = 0;

  axi4_lite_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ctl ();

  axi4_lite_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .grant     (grant),
    .ctl       (ctl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    logic [N-1:0] exp_g;
    int           idx;

    arst_n       = 1'b0;
    req_valid    = '0;
    req_we       = '0;
    req_addr     = '0;
    req_wdata    = '0;
    ctl.wr_ready = 1'b0;
    ctl.rd_ready = 1'b0;
    ctl.rd_data  = '0;

    // Reset state
    step();
    chk("rst_grant", grant, 0);
    chk("rst_wr_valid", ctl.wr_valid, 0);
    chk("rst_rd_valid", ctl.rd_valid, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_wr_addr", ctl.wr_addr, 0);
    #2 arst_n = 1'b1;
    step();

    // Single write by requester 2, completion 3 cycles after command valid
    set_req(2, 1'b1, 32'h10, 32'hA5A5_A5A5);
    req_valid = 4'b0100;
    step();
    chk("w1_wr_valid", ctl.wr_valid, 1);
    chk("w1_rd_valid", ctl.rd_valid, 0);
    chk("w1_wr_addr", ctl.wr_addr, 32'h10);
    chk("w1_wr_data", ctl.wr_data, 32'hA5A5_A5A5);
    chk("w1_grant", grant, 4'b0100);
    req_valid = '0;
    step();
    step();
    chk("w1_wr_valid_hold", ctl.wr_valid, 1);
    chk("w1_no_done_early", req_done, 0);
    ctl.wr_ready = 1'b1;
    step();
    ctl.wr_ready = 1'b0;
    chk("w1_wr_valid_drop", ctl.wr_valid, 0);
    chk("w1_req_done", req_done, 4'b0100);
    chk("w1_grant_clear", grant, 0);
    step();
    chk("w1_done_one_cycle", req_done, 0);

    // Single read by requester 1
    set_req(1, 1'b0, 32'h20, 32'h0);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    chk("r1_rd_valid", ctl.rd_valid, 1);
    chk("r1_wr_valid", ctl.wr_valid, 0);
    chk("r1_rd_addr", ctl.rd_addr, 32'h20);
    chk("r1_grant", grant, 4'b0010);
    ctl.rd_data  = 32'hDEAD_BEEF;
    ctl.rd_ready = 1'b1;
    step();
    ctl.rd_ready = 1'b0;
    ctl.rd_data  = '0;
    chk("r1_rd_valid_drop", ctl.rd_valid, 0);
    chk("r1_req_rdata", req_rdata, 32'hDEAD_BEEF);
    chk("r1_req_done", req_done, 4'b0010);
    step();

    // Requester 0 write; its address input changes after grant
    set_req(0, 1'b1, 32'h10, 32'h1111_2222);
    req_valid = 4'b0001;
    step();
    chk("st_grant", grant, 4'b0001);
    set_req(0, 1'b1, 32'h44, 32'h3333_4444);
    step();
    chk("st_wr_addr_hold", ctl.wr_addr, 32'h10);
    chk("st_wr_data_hold", ctl.wr_data, 32'h1111_2222);
    req_valid = '0;
    ctl.wr_ready = 1'b1;
    step();
    ctl.wr_ready = 1'b0;
    chk("st_req_done", req_done, 4'b0001);
    chk("st_rdata_kept", req_rdata, 32'hDEAD_BEEF);
    step();

    // Stray ready pulses: wr_ready in IDLE, rd_ready in WR
    ctl.wr_ready = 1'b1;
    step();
    ctl.wr_ready = 1'b0;
    chk("sr_idle_grant", grant, 0);
    chk("sr_idle_done", req_done, 0);
    chk("sr_idle_wr_valid", ctl.wr_valid, 0);
    set_req(3, 1'b1, 32'h30, 32'h5555_6666);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    chk("sr_wr_grant", grant, 4'b1000);
    ctl.rd_data  = 32'h1234_5678;
    ctl.rd_ready = 1'b1;
    step();
    ctl.rd_ready = 1'b0;
    chk("sr_wr_valid_kept", ctl.wr_valid, 1);
    chk("sr_wr_no_done", req_done, 0);
    chk("sr_wr_grant_kept", grant, 4'b1000);
    chk("sr_rdata_kept", req_rdata, 32'hDEAD_BEEF);
    ctl.wr_ready = 1'b1;
    step();
    ctl.wr_ready = 1'b0;
    chk("sr_req_done", req_done, 4'b1000);
    step();

    // Reset in the middle of a write by requester 0 (last owner becomes 0,
    // so without reset requester 1 would win next)
    set_req(0, 1'b1, 32'h50, 32'h7777_8888);
    req_valid = 4'b0001;
    step();
    chk("rm_grant", grant, 4'b0001);
    #2 arst_n = 1'b0;
    #1;
    chk("rm_wr_valid_async", ctl.wr_valid, 0);
    chk("rm_grant_async", grant, 0);
    set_req(1, 1'b1, 32'h60, 32'h9999_AAAA);
    req_valid = 4'b0011;
    step();
    chk("rm_no_done", req_done, 0);
    #2 arst_n = 1'b1;
    step();
    chk("rm_first_winner", grant, 4'b0001);
    chk("rm_wr_addr", ctl.wr_addr, 32'h50);

    // Fairness out of reset: all four hold requests; 0,2 write, 1,3 read
    #2 arst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, (i % 2) == 0, 32'h100 * (i + 1), 32'hC0DE_0000 + i);
    req_valid = 4'b1111;
    step();
    chk("fr_reset_grant", grant, 0);
    #2 arst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idx   = k % N;
      exp_g = 4'b0001 << idx;
      step();
      chk($sformatf("fr_grant_%0d", k), grant, exp_g);
      if ((idx % 2) == 0) begin
        chk($sformatf("fr_wr_addr_%0d", k), ctl.wr_addr, 32'h100 * (idx + 1));
        chk($sformatf("fr_rd_valid_%0d", k), ctl.rd_valid, 0);
        ctl.wr_ready = 1'b1;
      end else begin
        chk($sformatf("fr_rd_addr_%0d", k), ctl.rd_addr, 32'h100 * (idx + 1));
        chk($sformatf("fr_wr_valid_%0d", k), ctl.wr_valid, 0);
        ctl.rd_data  = 32'hBEEF_0000 + k;
        ctl.rd_ready = 1'b1;
      end
      step();
      ctl.wr_ready = 1'b0;
      ctl.rd_ready = 1'b0;
      chk($sformatf("fr_idle_grant_%0d", k), grant, 0);
      chk($sformatf("fr_done_%0d", k), req_done, exp_g);
    end
    chk("fr_last_rdata", req_rdata, 32'hBEEF_0003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
